// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-side transmitter and its line filter.
package ps2_host_tx_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Common host-to-device command bytes and the device's acknowledge byte.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ACK_BYTE = 8'hFA;

  // Number of consecutive equal synchronized samples before the filtered level moves.
  localparam int FILTER_LEN = 4;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, agreement filter and falling-edge strobe.
// Also suitable for the receiver side.
module ps2_host_tx_line_filter
  import ps2_host_tx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic [FILTER_LEN-2:0] hist_q;
  logic                  level_q;
  logic                  level_d;
  logic                  fall_q;
  logic                  fall_d;

  // Filtered level follows the line only when the current and the last three samples agree
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    level_d = level_q;
    if (sync2_q && (&hist_q)) begin
      level_d = 1'b1;
    end else if (!sync2_q && !(|hist_q)) begin
      level_d = 1'b0;
    end
    fall_d = level_q & ~level_d;
  end

  // Synchronizer, sample history, filtered level and edge strobe; idle lines read high
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples the values from before the edge.
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[FILTER_LEN-3:0], sync2_q};
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock the byte out
// against the device clock, then check the device's acknowledge bit.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       rx_inhibit_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q, state_d;
  logic [9:0]       frame_q, frame_d;      // {stop, parity, d7..d0}, shifted out LSB first
  logic [3:0]       bit_idx_q, bit_idx_d;  // falling edges seen since the request
  logic [CNT_W-1:0] cnt_q, cnt_d;          // inhibit timer, then inter-edge timeout
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ev_done, ev_error;

  logic clk_level, clk_fall;
  logic data_level;
  logic data_fall_unused;  // data edges are not needed by the transmitter

  ps2_host_tx_line_filter u_clk_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_host_tx_line_filter u_data_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (ps2_data_i),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  // State and datapath registers, plus the registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next state: protocol sequencing, bit shifting and the shared inhibit/timeout counter
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    ev_done   = 1'b0;
    ev_error  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid_i && tx_ready_q) begin
          frame_d   = {1'b1, odd_parity(tx_data_i), tx_data_i};
          bit_idx_d = '0;
          cnt_d     = '0;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        cnt_d = clk_fall ? '0 : cnt_q + CNT_W'(1);
        if (state_q == ST_WAIT_IDLE && clk_level && data_level) begin
          ev_done = 1'b1;
          state_d = ST_IDLE;
        end else if (!clk_fall && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ev_error = 1'b1;
          state_d  = ST_IDLE;
        end else if (clk_fall) begin
          case (state_q)
            ST_REQ, ST_SEND: begin
              frame_d   = {1'b1, frame_q[9:1]};
              bit_idx_d = bit_idx_q + 4'd1;
              // Edge 10 has just put out the stop bit; the device answers on edge 11.
              state_d   = (bit_idx_q == 4'd9) ? ST_ACK : ST_SEND;
            end
            ST_ACK: begin
              if (data_level) begin
                ev_error = 1'b1;
                state_d  = ST_IDLE;
              end else begin
                state_d = ST_WAIT_IDLE;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs, computed from the upcoming state so every pin comes straight from a flop
  always_comb begin
    // tx_ready comes back one cycle after the done/error pulse.
    tx_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    busy_d     = ~tx_ready_d;
    clk_oe_d   = (state_d == ST_INHIBIT);
    done_d     = ev_done;
    error_d    = ev_error;
    case (state_d)
      ST_REQ:  data_oe_d = 1'b1;  // start bit
      ST_SEND: data_oe_d = clk_fall ? ~frame_q[0] : data_oe_q;
      default: data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready_o    = tx_ready_q;
  assign busy_o        = busy_q;
  assign rx_inhibit_o  = busy_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_oe, data_oe, busy, rx_inhibit, done, error;

  // Device side of the open-drain bus
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic glitch = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = ~clk_oe & dev_clk & ~glitch;
  assign ps2_data_line = ~data_oe & dev_data;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rdy_busy_cnt = 0, inh_mis_cnt = 0;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .ps2_clk_i     (ps2_clk_line),
    .ps2_data_i    (ps2_data_line),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe),
    .busy_o        (busy),
    .rx_inhibit_o  (rx_inhibit),
    .done_o        (done),
    .error_o       (error)
  );

  // Pulse and invariant monitor
  always @(negedge clk) begin
    if (done)                done_cnt     <= done_cnt + 1;
    if (error)               err_cnt      <= err_cnt + 1;
    if (done && error)       both_cnt     <= both_cnt + 1;
    if (tx_ready && busy)    rdy_busy_cnt <= rdy_busy_cnt + 1;
    if (rx_inhibit !== busy) inh_mis_cnt  <= inh_mis_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte, wait for acceptance, then measure the inhibit phase.
  task automatic start_tx(input logic [7:0] d, input bit hold, input logic [7:0] next_d,
                          input string tag, output int waited);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready_seen"}, tx_ready, 1'b1);
    @(negedge clk);
    if (hold) tx_data = next_d;
    else      tx_valid = 1'b0;
    check({tag, "_accept_clk_oe"}, {tx_ready, busy, rx_inhibit, clk_oe, data_oe}, 5'b01110);
    n = 0;
    while (clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_inhibit_len"}, n, INH);
    check({tag, "_req_data_oe"}, data_oe, 1'b1);
  endtask

  // Device clocks the frame out; returns early (clock held low) if reset_edge is reached.
  task automatic device_frame(input int glitch_edge, input bit do_ack, input int reset_edge,
                              output logic [10:0] bits);
    bits = '0;
    repeat (50) @(negedge clk);
    bits[0] = ps2_data_line;
    for (int e = 1; e <= 10; e++) begin
      dev_clk = 1'b0;
      if (e == reset_edge) begin
        repeat (25) @(negedge clk);
        return;
      end
      repeat (50) @(negedge clk);
      dev_clk = 1'b1;
      bits[e] = ps2_data_line;
      if (e == glitch_edge) begin
        repeat (20) @(negedge clk);
        glitch = 1'b1;
        repeat (2) @(negedge clk);
        glitch = 1'b0;
        repeat (28) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
    end
    if (do_ack) dev_data = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (50) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    dev_data = 1'b1;
  endtask

  // Run the device side, check the frame bits, and stop on the done/error pulse.
  task automatic finish_frame(input logic [7:0] d, input logic par, input int glitch_edge,
                              input string tag);
    logic [10:0] bits;
    int n;
    device_frame(glitch_edge, 1'b1, 0, bits);
    check({tag, "_frame_bits"}, bits, {1'b1, par, d, 1'b0});
    n = 0;
    while (!done && !error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_err"}, {done, error}, 2'b10);
    check({tag, "_ready_in_pulse"}, tx_ready, 1'b0);
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_after"}, {tx_ready, busy, clk_oe, data_oe, done, error}, 6'b100000);
  endtask

  task automatic run_ok(input logic [7:0] d, input logic par, input int glitch_edge,
                        input string tag);
    int w;
    start_tx(d, 1'b0, 8'h00, tag, w);
    finish_frame(d, par, glitch_edge, tag);
    post_idle(tag);
  endtask

  initial begin
    logic [10:0] bits;
    int w, c, d0, e0;

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_outputs", {tx_ready, busy, rx_inhibit, done, error, clk_oe, data_oe}, 7'b1000000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", {tx_ready, busy, clk_oe, data_oe}, 4'b1000);

    // 1: set-LEDs, parity 1
    run_ok(CMD_SET_LEDS, 1'b1, 0, "t1_ed");

    // 2: back-to-back, second request held high while busy
    start_tx(CMD_RESET, 1'b1, 8'h01, "t2_ff", w);
    finish_frame(CMD_RESET, 1'b1, 0, "t2_ff");
    start_tx(8'h01, 1'b0, 8'h00, "t2_01", w);
    check("t2_second_wait", w, 1);
    finish_frame(8'h01, 1'b0, 0, "t2_01");
    post_idle("t2_01");

    // 3: device never acknowledges
    start_tx(CMD_ACK_BYTE, 1'b0, 8'h00, "t3_noack", w);
    d0 = done_cnt;
    e0 = err_cnt;
    device_frame(0, 1'b0, 0, bits);
    check("t3_frame_bits", bits, {1'b1, 1'b1, CMD_ACK_BYTE, 1'b0});
    repeat (3) @(negedge clk);
    check("t3_err_pulses", err_cnt - e0, 1);
    check("t3_done_pulses", done_cnt - d0, 0);
    check("t3_released", {tx_ready, clk_oe, data_oe}, 3'b100);

    // 4: device never clocks after the request
    start_tx(CMD_RESET, 1'b0, 8'h00, "t4_tmo", w);
    c = 0;
    while (!error && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("t4_timeout_cycles", c, TMO);
    check("t4_oe_released", {clk_oe, data_oe, done}, 3'b000);
    @(negedge clk);
    check("t4_ready", tx_ready, 1'b1);

    // 5: reset while d4 is on the line, then a normal send
    start_tx(CMD_SET_LEDS, 1'b0, 8'h00, "t5_rst", w);
    device_frame(0, 1'b1, 5, bits);
    check("t5_d4_driven", data_oe, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_release", {clk_oe, data_oe, tx_ready, busy}, 4'b0010);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
    check("t5_idle", {tx_ready, clk_oe, data_oe}, 3'b100);
    run_ok(CMD_ENABLE, 1'b0, 0, "t5_f4");

    // 6: 2-cycle clock glitch during SEND
    run_ok(8'h5A, 1'b1, 4, "t6_glitch");

    // Whole-run invariants
    repeat (2) @(negedge clk);
    check("total_done", done_cnt, 5);
    check("total_error", err_cnt, 2);
    check("done_error_overlap", both_cnt, 0);
    check("ready_while_busy", rdy_busy_cnt, 0);
    check("rx_inhibit_eq_busy", inh_mis_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the sending counterpart of the PS/2 keyboard receiver. It accepts one command byte from the MIO bus (e.g. 0xED set-LEDs, 0xFF reset), inhibits the bus, issues a request-to-send and clocks the byte out against the device-generated clock. It then checks the device's acknowledge bit. It drives the open-drain PS/2 lines and tells the receiver to ignore the lines while a transmission is in progress.

## Interface
- INHIBIT_CYCLES, 12000: clock-low inhibit time in `clk` cycles (120 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum `clk` cycles between consecutive device clock falling edges before aborting (20 ms).
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte, sampled on accept.
- tx_valid  in  1  request to send; accepted when `tx_valid && tx_ready`.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in, ps2_data_in  in  1 each  raw pin levels (asynchronous).
- ps2_clk_oe, ps2_data_oe  out  1 each  1 = pull the line low, 0 = release it.
- busy  out  1  high in every state except IDLE.
- rx_inhibit  out  1  equal to busy; the receiver discards edges while it is high.
- done  out  1  one-cycle pulse on successful acknowledge.
- error  out  1  one-cycle pulse on missing ACK or timeout.

## Operation
- Each input goes through a 2-FF synchronizer and a 4-sample agreement filter; the filtered level changes only after 4 consecutive equal synced samples.
- A falling edge is a filtered-level transition from 1 to 0.
- parity = ~^tx_data, which gives odd parity.
- Frame bits, LSB first: start 0, d0..d7, parity, stop 1, then the device drives ACK 0.
- States:
  - IDLE: all oe 0. On accept, latch data and parity, clear the counter, go to INHIBIT.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=0, data_oe=1 (start bit). The first falling edge drives d0 and moves to SEND with bit index 1.
  - SEND: each falling edge drives the next bit. Edges 2..8 drive d1..d7, edge 9 drives parity, edge 10 releases data (stop). data_oe = ~bit. After edge 10, go to ACK.
  - ACK: on the next falling edge, sample the filtered data. 0 goes to WAIT_IDLE; 1 pulses error and goes to IDLE.
  - WAIT_IDLE: when filtered clock and data are both 1, pulse done and go to IDLE.
- Timeout: a counter runs in REQ, SEND, ACK and WAIT_IDLE and resets on every falling edge. When it reaches TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- tx_valid while busy is ignored; the requester holds it until tx_ready.
- A device frame already in progress at accept is overridden by the inhibit, as the protocol allows. The receiver's partial frame is discarded via rx_inhibit.

## Timing
- Reset values: state IDLE, tx_ready=1, busy=0, rx_inhibit=0, done=0, error=0, ps2_clk_oe=0, ps2_data_oe=0, filters preset to 1.
- Reset mid-frame releases both lines on the cycle after rst is sampled high. No done or error pulse follows.
- Accept cycle N: busy=1 and clk_oe=1 from N+1. clk_oe falls and data_oe rises together at N+1+INHIBIT_CYCLES.
- Pin-to-filtered latency is 6 cycles. data_oe is updated on the cycle after the falling edge is detected, well inside the device's clock-low half period (≥30 µs).
- done and error are mutually exclusive, one cycle each. tx_ready returns on the cycle after the pulse.
- All outputs are registered.

## Structure
- Shared header ps2_defs.vh holds:
  - state encodings (IDLE..WAIT_IDLE, 3 bits);
  - command constants: 0xED set-LEDs, 0xF4 enable, 0xFF reset, 0xFA ACK byte;
  - the filter length of 4.
- Sub-module ps2_line_filter (sync, agreement filter, falling-edge strobe) is instantiated twice, for clock and data. The receiver can reuse it.

## Test plan
Bench settings: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000. The device model toggles the clock with a 50-cycle half period, samples data on rising edges, and drives ACK.

1. Send 0xED: inhibit lasts exactly 20 cycles. The device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1, then drives ACK 0. One done pulse follows; error stays 0.
2. Send 0xFF then 0x01 back-to-back: parity 1 then 0. The second tx_valid is ignored until tx_ready returns. Two done pulses.
3. The device model does not drive ACK (data stays high at the 11th edge): one error pulse, lines released, tx_ready=1.
4. The device never clocks after the request: error pulses exactly 2000 cycles after REQ entry and both oe return to 0.
5. Assert rst during d4: both oe are 0 on the next cycle, then IDLE with tx_ready=1. A following send of 0xF4 completes with done.
6. A 2-cycle glitch low on ps2_clk_in during SEND: no bit advance, and the frame completes correctly.
